wb_spram_ctrl: RTL and testbench

//  Wishbone B4 pipelined slave driving a single-port 32-bit RAM (addr/ce/we/d/q, registered q, 1-cycle read).

---
 rtl/wb_spram_pkg.sv | 15 +
 rtl/spram_clear_seq.sv | 52 +++++
 rtl/wb_spram_ctrl.sv | 135 +++++++++++++
 tb/tb_wb_spram_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_spram_pkg
//  Description : Shared types and constants for the Wishbone single-port RAM
//                controller (FSM state encoding, RAM word size).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_spram_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam int WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/spram_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spram_clear_seq
//  Description : Post-reset zero-fill sequencer. Walks the RAM word addresses
//                from 0 upward while enabled, flags the final word, and
//                supplies the constant write strobe/data for the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_clear_seq
  import wb_spram_pkg::*;
#(
  parameter int WORDS      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    last_o,
  output logic [WORD_BYTES-1:0]   we_o,
  output logic [31:0]             d_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  // Advance one word per cycle while the sweep is active.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Sweep counter; any reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr_o = cnt_q;
  assign last_o = (cnt_q == LAST_ADDR);
  assign we_o   = '1;
  assign d_o    = '0;

endmodule
`default_nettype wire

// File: rtl/wb_spram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_spram_ctrl
//  Description : Wishbone B4 pipelined slave in front of a single-port 32-bit
//                RAM with registered read data. One transfer per clock,
//                completion one cycle after acceptance. Optionally zero-fills
//                the RAM after reset while stalling the bus.
//  Options     : WB_SPRAM_ERR_EN - requests with address bits above the RAM
//                range complete with wb_err_o and do not touch the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_spram_ctrl
  import wb_spram_pkg::*;
#(
  parameter int SIZE           = 'h80,
  parameter int ADDR_WIDTH     = $clog2(SIZE) - 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic                  init_done_o,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_d,
  input  logic [31:0]           ram_q
);

  localparam int     WORDS       = SIZE / WORD_BYTES;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    w_bad_adr;
  logic [ADDR_WIDTH-1:0]   w_clr_addr;
  logic                    w_clr_last;
  logic [WORD_BYTES-1:0]   w_clr_we;
  logic [31:0]             w_clr_d;
  logic                    w_unused;

  // Byte-offset bits never reach the RAM; upper bits only matter for errors.
  assign w_unused = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

`ifdef WB_SPRAM_ERR_EN
  assign w_bad_adr = |wb_adr_i[31:ADDR_WIDTH+2];
`else
  assign w_bad_adr = 1'b0;
`endif

  spram_clear_seq #(
    .WORDS      (WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == ST_CLEAR),
    .addr_o (w_clr_addr),
    .last_o (w_clr_last),
    .we_o   (w_clr_we),
    .d_o    (w_clr_d)
  );

  // Next state, RAM port mux and completion scheduling.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    wb_stall_o  = 1'b1;
    init_done_o = 1'b0;
    ram_ce      = 1'b0;
    ram_we      = 4'h0;
    ram_addr    = wb_adr_i[ADDR_WIDTH+1:2];
    ram_d       = wb_dat_i;
    case (state_q)
      ST_CLEAR: begin
        ram_ce   = 1'b1;
        ram_we   = w_clr_we;
        ram_d    = w_clr_d;
        ram_addr = w_clr_addr;
        if (w_clr_last) begin
          state_d = ST_READY;
        end
      end
      default: begin
        wb_stall_o  = 1'b0;
        init_done_o = 1'b1;
        if (wb_cyc_i && wb_stb_i && rst_n) begin
          if (w_bad_adr) begin
            err_d = 1'b1;
          end else begin
            ram_ce = 1'b1;
            ram_we = wb_we_i ? wb_sel_i : 4'h0;
            ack_d  = 1'b1;
          end
        end
      end
    endcase
    // Keep the RAM idle for the whole reset window.
    if (!rst_n) begin
      ram_ce = 1'b0;
      ram_we = 4'h0;
    end
  end

  // State register and one-deep completion pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // A dropped cycle suppresses the pending completion.
  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;
  assign wb_dat_o = wb_ack_o ? ram_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_spram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_spram_ctrl
//  Description : Directed self-checking bench for wb_spram_ctrl with a
//                behavioural single-port RAM (registered read, byte writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_spram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o, init_done_o;
  logic [4:0]  ram_addr;
  logic        ram_ce;
  logic [3:0]  ram_we;
  logic [31:0] ram_d;
  logic [31:0] ram_q;

  logic [31:0] mem [0:31];
  logic        fill_req;
  logic [31:0] fill_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_spram_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_sel_i    (wb_sel_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .wb_stall_o  (wb_stall_o),
    .init_done_o (init_done_o),
    .ram_addr    (ram_addr),
    .ram_ce      (ram_ce),
    .ram_we      (ram_we),
    .ram_d       (ram_d),
    .ram_q       (ram_q)
  );

  // Behavioural RAM: read-before-write, registered q, plus a bulk prefill.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= fill_val;
    end else if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      ram_q <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset one edge (prefilling the RAM with junk), check reset outputs, release.
  task automatic do_reset();
    rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    fill_val = 32'hA5A5_A5A5; fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    #1;
    check("rst_ce",        {31'd0, ram_ce},      32'd0);
    check("rst_we",        {28'd0, ram_we},      32'd0);
    check("rst_stall",     {31'd0, wb_stall_o},  32'd1);
    check("rst_init_done", {31'd0, init_done_o}, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  // Follow the sweep until stall drops; returns sweep length and bad cycles.
  task automatic sweep(output int n, output int bad);
    n = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!wb_stall_o) break;
      if (int'(ram_addr) != n || ram_we != 4'hF || !ram_ce || ram_d != 32'h0 || init_done_o) bad++;
      n++;
      step();
    end
  endtask

  task automatic check_zero_mem(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 32'h0) nz++;
    check(tag, nz, 0);
  endtask

  // Single transfer: returns completion flags, read data and RAM strobes at accept.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic ack, output logic err,
                      output logic [31:0] dato, output logic ce_acc, output logic [3:0] we_acc);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    #1;
    ce_acc = ram_ce; we_acc = ram_we;
    step();
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    #1;
    ack = wb_ack_o; err = wb_err_o; dato = wb_dat_o;
    step();
    wb_cyc_i = 1'b0;
  endtask

  initial begin
    int          n, bad;
    logic        ack, err, ce_acc;
    logic [3:0]  we_acc;
    logic [31:0] dato;

    rst_n = 1'b0; fill_req = 1'b0; fill_val = 32'h0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;

    // Full sweep after reset: 32 zero writes then ready.
    do_reset();
    sweep(n, bad);
    check("sweep_len", n, 32);
    check("sweep_bad", bad, 0);
    check("init_done", {31'd0, init_done_o}, 32'd1);
    check_zero_mem("sweep_zero");
    check("idle_dat", wb_dat_o, 32'h0);
    xfer(1'b0, 32'h7C, 4'hF, 32'h0, ack, err, dato, ce_acc, we_acc);
    check("rd7c_ack", {31'd0, ack}, 32'd1);
    check("rd7c_dat", dato, 32'h0);

    // Reset in the middle of the sweep restarts it at word 0.
    do_reset();
    for (int i = 0; i < 10; i++) step();
    #1;
    check("abort_addr", {27'd0, ram_addr}, 32'd10);
    rst_n = 1'b0; fill_val = 32'h5A5A_5A5A; fill_req = 1'b1;
    step();
    fill_req = 1'b0; rst_n = 1'b1;
    sweep(n, bad);
    check("resweep_len", n, 32);
    check("resweep_bad", bad, 0);
    check_zero_mem("resweep_zero");

    // Full-word write and read back.
    xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, ack, err, dato, ce_acc, we_acc);
    check("wr_ack", {31'd0, ack}, 32'd1);
    check("wr_err", {31'd0, err}, 32'd0);
    check("wr_we",  {28'd0, we_acc}, 32'hF);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, ack, err, dato, ce_acc, we_acc);
    check("rd_ack", {31'd0, ack}, 32'd1);
    check("rd_dat", dato, 32'hDEAD_BEEF);

    // Byte-lane write, then an all-lanes-off write.
    xfer(1'b1, 32'h10, 4'b0100, 32'h00AA_0000, ack, err, dato, ce_acc, we_acc);
    check("lane_ack", {31'd0, ack}, 32'd1);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, ack, err, dato, ce_acc, we_acc);
    check("lane_dat", dato, 32'hDEAA_BEEF);
    xfer(1'b1, 32'h10, 4'h0, 32'h1234_5678, ack, err, dato, ce_acc, we_acc);
    check("sel0_ack", {31'd0, ack}, 32'd1);
    check("sel0_ce",  {31'd0, ce_acc}, 32'd1);
    check("sel0_we",  {28'd0, we_acc}, 32'h0);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, ack, err, dato, ce_acc, we_acc);
    check("sel0_dat", dato, 32'hDEAA_BEEF);

    // Back-to-back reads with strobe held.
    xfer(1'b1, 32'h0, 4'hF, 32'h1111_1111, ack, err, dato, ce_acc, we_acc);
    xfer(1'b1, 32'h4, 4'hF, 32'h2222_2222, ack, err, dato, ce_acc, we_acc);
    xfer(1'b1, 32'h8, 4'hF, 32'h3333_3333, ack, err, dato, ce_acc, we_acc);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    step();
    wb_adr_i = 32'h4;
    #1;
    check("pipe_ack0", {31'd0, wb_ack_o}, 32'd1);
    check("pipe_dat0", wb_dat_o, 32'h1111_1111);
    step();
    wb_adr_i = 32'h8;
    #1;
    check("pipe_ack1", {31'd0, wb_ack_o}, 32'd1);
    check("pipe_dat1", wb_dat_o, 32'h2222_2222);
    step();
    wb_stb_i = 1'b0;
    #1;
    check("pipe_ack2", {31'd0, wb_ack_o}, 32'd1);
    check("pipe_dat2", wb_dat_o, 32'h3333_3333);
    step();
    #1;
    check("pipe_ack_end", {31'd0, wb_ack_o}, 32'd0);

    // Cycle dropped before completion: no acknowledge.
    wb_stb_i = 1'b1; wb_adr_i = 32'h0;
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
    check("drop_ack", {31'd0, wb_ack_o}, 32'd0);
    step();

    // Out-of-range address.
    xfer(1'b1, 32'h200, 4'hF, 32'hCAFE_F00D, ack, err, dato, ce_acc, we_acc);
`ifdef WB_SPRAM_ERR_EN
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_ack", {31'd0, ack}, 32'd0);
    check("oor_ce",  {31'd0, ce_acc}, 32'd0);
    check("oor_mem", mem[0], 32'h1111_1111);
`else
    check("alias_ack", {31'd0, ack}, 32'd1);
    check("alias_err", {31'd0, err}, 32'd0);
    check("alias_mem", mem[0], 32'hCAFE_F00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
